// File: rtl/pipe_reg_skid_pkg.sv
// pipe_reg_skid_pkg
//   Shared definitions for the inter-stage pipeline registers.
//   - PIPE_WIDTH_DEFAULT : default payload width used by every stage register.
//   - occ_e              : occupancy encoding reported on the occupancy port.
package pipe_reg_skid_pkg;

  localparam int unsigned PIPE_WIDTH_DEFAULT = 52;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_HALF  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_reg_skid_sat_counter.sv
// sat_counter
//   Saturating up-counter that adds 0..2 per cycle and sticks at all-ones.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset (count -> 0)
//     inc   : increment amount, 0..2
//     count : current count, CNT_W bits
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W:0] sum;
  logic [CNT_W:0] max_val;

  always_comb begin
    max_val = {1'b0, {CNT_W{1'b1}}};
    sum     = {1'b0, count} + (CNT_W+1)'(inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (sum > max_val) begin
      count <= '1;
    end else begin
      count <= sum[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid
//   Inter-stage pipeline register with valid/ready handshake and a 2-entry
//   skid buffer (main register drives the outputs, skid register absorbs one
//   extra payload while downstream stalls). Synchronous flush discards all
//   held entries and counts the discarded valid ones in a saturating counter.
//   Optional build macro PIPE_REG_BUBBLE_ZERO_EN: when defined, out_data is
//   forced to zero whenever out_valid is low.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     in_valid/in_ready   : upstream handshake, in_data payload
//     out_valid/out_ready : downstream handshake, out_data payload
//     flush               : synchronous discard of held entries
//     occupancy           : entries held (0..2), registered state
//     drop_cnt            : saturating count of valid entries lost to flush
module pipe_reg_skid
  import pipe_reg_skid_pkg::*;
#(
  parameter int unsigned WIDTH = PIPE_WIDTH_DEFAULT,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] drop_cnt
);

  logic             main_valid;
  logic             skid_valid;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             emit;
  logic [1:0]       drop_inc;
  occ_e             occ;

  // in_ready derives only from the skid flop plus flush, so a downstream
  // stall never reaches upstream through a combinational path.
  assign in_ready = !skid_valid && !flush;
  assign accept   = in_valid && in_ready;
  assign emit     = main_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid) begin
      if (accept) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end
    end else if (!skid_valid) begin
      if (accept && emit) begin
        main_data <= in_data;
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end else if (emit) begin
        main_valid <= 1'b0;
      end
    end else if (emit) begin
      main_data  <= skid_data;
      skid_valid <= 1'b0;
    end
  end

  // Entries discarded by flush: main only if it is not leaving this cycle.
  always_comb begin
    drop_inc = 2'd0;
    if (flush) begin
      drop_inc = {1'b0, main_valid && !emit} + {1'b0, skid_valid};
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_drop_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (drop_inc),
    .count(drop_cnt)
  );

  always_comb begin
    occ = OCC_EMPTY;
    if (skid_valid) begin
      occ = OCC_FULL;
    end else if (main_valid) begin
      occ = OCC_HALF;
    end
  end

  assign occupancy = occ;
  assign out_valid = main_valid;

`ifdef PIPE_REG_BUBBLE_ZERO_EN
  assign out_data = main_valid ? main_data : '0;
`else
  assign out_data = main_data;
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
module tb_pipe_reg_skid;

  localparam int unsigned WIDTH = 52;
  localparam int unsigned CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] drop_cnt;

  int checks;
  int errors;

  pipe_reg_skid #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .flush    (flush),
    .occupancy(occupancy),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 time
  // unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic fill_full(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = a;
    step();
    in_data = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== '0 || drop_cnt !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_init: got v=%b occ=%0d d=%h drop=%0d rdy=%b, want 0 0 0 0 1",
               out_valid, occupancy, out_data, drop_cnt, in_ready);
    end
    // Build up nonzero state, then reset mid-cycle with the buffer full.
    fill_full(52'h11, 52'h22);
    flush = 1'b1;
    step();
    flush = 1'b0;
    fill_full(52'h33, 52'h44);
    checks++;
    if (occupancy !== 2'd2 || drop_cnt !== 2'd2) begin
      errors++;
      $display("FAIL reset_pre: got occ=%0d drop=%0d, want 2 2", occupancy, drop_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== '0 || drop_cnt !== '0) begin
      errors++;
      $display("FAIL reset_async: got v=%b occ=%0d d=%h drop=%0d, want 0 0 0 0",
               out_valid, occupancy, out_data, drop_cnt);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b v=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] vals [3];
    vals[0] = 52'h1;
    vals[1] = 52'h2;
    vals[2] = 52'h3;
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vals[i];
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== vals[i] || occupancy !== 2'd1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b d=%h occ=%0d rdy=%b, want 1 %h 1 1",
                 i, out_valid, out_data, occupancy, in_ready, vals[i]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL stream_drain: got v=%b occ=%0d, want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fill_full(52'hA, 52'hB);
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 52'hA) begin
      errors++;
      $display("FAIL bp_full: got occ=%0d rdy=%b v=%b d=%h, want 2 0 1 a",
               occupancy, in_ready, out_valid, out_data);
    end
    // Upstream keeps offering while full; it must not be taken.
    in_valid  = 1'b1;
    in_data   = 52'hC;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== 52'hB || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_emit: got occ=%0d rdy=%b v=%b d=%h, want 1 1 1 b",
               occupancy, in_ready, out_valid, out_data);
    end
    step();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got occ=%0d v=%b, want 0 0", occupancy, out_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    fill_full(52'h7, 52'h8);
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got rdy=%b, want 0", in_ready);
    end
    in_valid = 1'b1;
    in_data  = 52'h9;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || drop_cnt !== 2'd2) begin
      errors++;
      $display("FAIL flush_full_stall: got occ=%0d v=%b drop=%0d, want 0 0 2",
               occupancy, out_valid, drop_cnt);
    end
    do_reset();
    fill_full(52'h7, 52'h8);
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || drop_cnt !== 2'd1) begin
      errors++;
      $display("FAIL flush_full_emit: got occ=%0d v=%b drop=%0d, want 0 0 1",
               occupancy, out_valid, drop_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] exp_cnt [4];
    exp_cnt[0] = 2'd2;
    exp_cnt[1] = 2'd3;
    exp_cnt[2] = 2'd3;
    exp_cnt[3] = 2'd3;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fill_full(52'h100 + 52'(i), 52'h200 + 52'(i));
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if (drop_cnt !== exp_cnt[i]) begin
        errors++;
        $display("FAIL sat_%0d: got drop=%0d, want %0d", i, drop_cnt, exp_cnt[i]);
      end
    end
  endtask

  task automatic test_bubble();
    logic [WIDTH-1:0] exp_idle;
`ifdef PIPE_REG_BUBBLE_ZERO_EN
    exp_idle = '0;
`else
    exp_idle = 52'h5;
`endif
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 52'h5;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 52'h5) begin
      errors++;
      $display("FAIL bubble_load: got v=%b d=%h, want 1 5", out_valid, out_data);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== exp_idle) begin
      errors++;
      $display("FAIL bubble_idle: got v=%b d=%h, want 0 %h", out_valid, out_data, exp_idle);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_bubble();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
